hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 78 +++++++
 tb/tb_hazard_scoreboard.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard beside ID: stalls PC and IF/ID until sources and WAW destinations are forwardable.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter output.
module hazard_scoreboard #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned RAW   = $clog2(NREG),
   parameter int unsigned LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RAW-1:0]   id_rs1,
   input  logic [RAW-1:0]   id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [RAW-1:0]   id_rd,
   input  logic             id_we,
   input  logic [LAT_W-1:0] id_lat,
   input  logic             id_flush,
   output logic             stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic [NREG-1:0]  busy_mask
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   logic [LAT_W-1:0] cnt [NREG];
   logic             rs1_haz;
   logic             rs2_haz;
   logic             waw_haz;
   logic             issue;

   // Hazard detection from registered counters and the current ID instruction
   always_comb begin
      rs1_haz = id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0);
      rs2_haz = id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0);
      waw_haz = id_we && (id_rd != '0) && (id_lat != '0) && (cnt[id_rd] > id_lat);
      stall   = id_valid && !id_flush && (rs1_haz || rs2_haz || waw_haz);
      issue   = id_valid && !id_flush && !stall;
   end

   assign pc_write    = ~stall;
   assign if_id_write = ~stall;

   // Countdown per register; an issuing write reloads and takes priority over the decrement
   always_ff @(posedge clk) begin
      for (int unsigned r = 0; r < NREG; r++) begin
         if (rst || r == 0) begin
            cnt[r] <= '0;
         end else if (issue && id_we && (id_rd == RAW'(r)) && (id_lat != '0)) begin
            cnt[r] <= id_lat;
         end else if (cnt[r] != '0) begin
            cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         busy_mask[r] = (cnt[r] != '0);
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   // Saturating count of cycles spent stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed per-cycle vectors push expectations, a negedge monitor checks them.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic [4:0]  id_rd;
   logic        id_we;
   logic [2:0]  id_lat;
   logic        id_flush;
   logic        stall;
   logic        pc_write;
   logic        if_id_write;
   logic [31:0] busy_mask;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       nm;
      logic        st;
      logic [31:0] bm;
      int          sc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_we       (id_we),
      .id_lat      (id_lat),
      .id_flush    (id_flush),
      .stall       (stall),
      .pc_write    (pc_write),
      .if_id_write (if_id_write),
      .busy_mask   (busy_mask)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   // Apply one cycle of ID inputs and record what the outputs must be during that cycle
   task automatic cyc(input logic r, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic [2:0] lat,
                      input logic fl, input logic es, input logic [31:0] eb,
                      input int esc, input string nm);
      exp_t e;
      rst = r; id_valid = v;
      id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_we = we; id_lat = lat; id_flush = fl;
      e.nm = nm; e.st = es; e.bm = eb; e.sc = esc;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are presented every cycle, so pop one expectation per cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (stall !== e.st || pc_write !== ~e.st || if_id_write !== ~e.st || busy_mask !== e.bm) begin
            failures++;
            $display("FAIL %s: stall=%0b pc_write=%0b if_id_write=%0b busy=%h, expected stall=%0b busy=%h",
                     e.nm, stall, pc_write, if_id_write, busy_mask, e.st, e.bm);
         end
`ifdef HAZARD_STALL_CNT_EN
         checks++;
         if (stall_cycles !== 32'(e.sc)) begin
            failures++;
            $display("FAIL %s_cnt: stall_cycles=%0d expected=%0d", e.nm, stall_cycles, e.sc);
         end
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
      id_rs2_used = 1'b0; id_rd = '0; id_we = 1'b0; id_lat = '0; id_flush = 1'b0;
      @(posedge clk);
      #1;
      //   rst v  rs1 u1 rs2 u2 rd we lat fl  stall busy          sc
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,        0,  "reset");
      // load-use, latency 1
      cyc(0, 1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 32'h0,        0,  "lu_issue");
      cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 32'h20,       0,  "lu_stall");
      cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 32'h0,        1,  "lu_go");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,        1,  "rst_a");
      // long op, latency 4
      cyc(0, 1, 0, 0, 0, 0, 7, 1, 4, 0,  0, 32'h0,        0,  "long_issue");
      cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 32'h80,       0,  "long_s1");
      cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 32'h80,       1,  "long_s2");
      cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 32'h80,       2,  "long_s3");
      cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 32'h80,       3,  "long_s4");
      cyc(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  0, 32'h0,        4,  "long_go");
      // x0 never tracked, unused sources ignored
      cyc(0, 1, 0, 0, 0, 0, 0, 1, 3, 0,  0, 32'h0,        4,  "x0_issue");
      cyc(0, 1, 0, 0, 0, 0, 9, 1, 3, 0,  0, 32'h0,        4,  "r9_issue");
      cyc(0, 1, 9, 0, 0, 1, 0, 0, 0, 0,  0, 32'h200,      4,  "unused_3");
      cyc(0, 1, 9, 0, 0, 1, 0, 0, 0, 0,  0, 32'h200,      4,  "unused_2");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h200,      4,  "r9_cnt1");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,        4,  "r9_done");
      // WAW ordering and reload
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 5, 0,  0, 32'h0,        4,  "waw_old");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  1, 32'h8,        4,  "waw_c5");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  1, 32'h8,        5,  "waw_c4");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  1, 32'h8,        6,  "waw_c3");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  1, 32'h8,        7,  "waw_c2");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 32'h8,        8,  "waw_c1_go");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 6, 0,  0, 32'h8,        8,  "waw_lat6");
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 5, 0,  1, 32'h8,        8,  "waw_reload6");
      // flushed instruction: no stall, no reload
      cyc(0, 1, 0, 0, 0, 0, 3, 1, 5, 1,  0, 32'h8,        9,  "flush");
      cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8,        9,  "fl_c4");
      cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8,        10, "fl_c3");
      cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8,        11, "fl_c2");
      cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 32'h8,        12, "fl_c1");
      cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 32'h0,        13, "fl_go");
      // reset while an entry is in flight
      cyc(0, 1, 0, 0, 0, 0, 4, 1, 3, 0,  0, 32'h0,        13, "r4_issue");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h10,       13, "r4_rst");
      cyc(0, 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 32'h0,        0,  "after_rst");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,        0,  "idle");
      @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
